// File: rtl/ask_pkg.sv
// ASK link shared definitions: frame state encoding and default framing constants.
// Used by both the transmitter (ask_frame_tx) and the on-chip receiver.
package ask_pkg;

  // Frame progress of the transmitter
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SYNC     = 2'd2,
    ST_DATA     = 2'd3
  } ask_state_e;

  localparam int unsigned ASK_PREAMBLE_WIDTH = 8;
  localparam int unsigned ASK_SYNCWORD_WIDTH = 8;
  localparam int unsigned ASK_DATA_WIDTH     = 8;
  localparam int unsigned ASK_PRESCALER      = 4;

  // 10101010 at prescaler 4 yields the receiver's F0F0F0F0 sample template
  localparam logic [ASK_PREAMBLE_WIDTH-1:0] ASK_PREAMBLE = 8'b1010_1010;
  localparam logic [ASK_SYNCWORD_WIDTH-1:0] ASK_SYNCWORD = 8'b1110_0101;

endpackage

// File: rtl/ask_symbol_timer.sv
// Symbol prescaler: counts 0..PRESCALER-1 while enabled and flags the last
// clk cycle of each symbol. restart forces the count back to the start of a symbol.
module ask_symbol_timer #(
  parameter int unsigned PRESCALER = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic strobe_c
);

  localparam int unsigned CNT_WIDTH = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PRESCALER - 1);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Prescale counter, parked at zero while idle
  always_ff @(posedge clk) begin
    if (reset || restart || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign strobe_c = enable & (cnt_q == CNT_LAST);

endmodule

// File: rtl/ask_frame_tx.sv
// ASK frame transmitter: serialises {PREAMBLE, SYNCWORD, data} MSB first,
// each symbol held SYMBCLK_PRESCALER clk cycles, with a one-cycle sent pulse.
// Optional build macro ASK_TX_QUEUE_EN adds a one-entry pending request so
// frames can run back to back without the idle cycle.
module ask_frame_tx
  import ask_pkg::*;
#(
  parameter int unsigned                   PREAMBLE_WIDTH    = ASK_PREAMBLE_WIDTH,
  parameter logic [PREAMBLE_WIDTH-1:0]     PREAMBLE          = PREAMBLE_WIDTH'(ASK_PREAMBLE),
  parameter int unsigned                   SYNCWORD_WIDTH    = ASK_SYNCWORD_WIDTH,
  parameter logic [SYNCWORD_WIDTH-1:0]     SYNCWORD          = SYNCWORD_WIDTH'(ASK_SYNCWORD),
  parameter int unsigned                   DATA_WIDTH        = ASK_DATA_WIDTH,
  parameter int unsigned                   SYMBCLK_PRESCALER = ASK_PRESCALER
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  send,
  output logic                  ready,
  output logic                  busy,
  output logic                  dataout,
  output logic                  sent
);

  localparam int unsigned FRAME_WIDTH   = PREAMBLE_WIDTH + SYNCWORD_WIDTH + DATA_WIDTH;
  localparam int unsigned BIT_CNT_WIDTH = $clog2(FRAME_WIDTH + 1);

  localparam logic [BIT_CNT_WIDTH-1:0] CNT_SYNC  = BIT_CNT_WIDTH'(PREAMBLE_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0] CNT_DATA  = BIT_CNT_WIDTH'(PREAMBLE_WIDTH + SYNCWORD_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0] CNT_FRAME = BIT_CNT_WIDTH'(FRAME_WIDTH);

  ask_state_e               state_q, state_d;
  logic [FRAME_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_inc_c;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;
  logic                     dataout_q, dataout_d;
  logic                     sent_q, sent_d;
  logic                     accept_c;
  logic                     load_c;
  logic [DATA_WIDTH-1:0]    load_data_c;
  logic                     strobe_c;

`ifdef ASK_TX_QUEUE_EN
  logic                     pending_q, pending_d;
  logic [DATA_WIDTH-1:0]    pending_data_q, pending_data_d;
`endif

  // Symbol boundary generator; restarted whenever a new frame is loaded
  ask_symbol_timer #(
    .PRESCALER (SYMBCLK_PRESCALER)
  ) u_symbol_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (busy_q),
    .restart  (load_c),
    .strobe_c (strobe_c)
  );

  // Next-state, shift register, counters and output levels
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    busy_d        = busy_q;
    dataout_d     = dataout_q;
    sent_d        = 1'b0;
    accept_c      = send & ready_q;
    load_c        = 1'b0;
    load_data_c   = data;
    bit_cnt_inc_c = bit_cnt_q + BIT_CNT_WIDTH'(1);
`ifdef ASK_TX_QUEUE_EN
    pending_d      = pending_q;
    pending_data_d = pending_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          load_c = 1'b1;
        end
      end
      default: begin
`ifdef ASK_TX_QUEUE_EN
        if (accept_c) begin
          pending_d      = 1'b1;
          pending_data_d = data;
        end
`endif
        if (strobe_c) begin
          shreg_d   = shreg_q << 1;
          dataout_d = shreg_q[FRAME_WIDTH-2];
          bit_cnt_d = bit_cnt_inc_c;
          if (bit_cnt_inc_c == CNT_FRAME) begin
            sent_d    = 1'b1;
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            dataout_d = 1'b0;
            bit_cnt_d = '0;
`ifdef ASK_TX_QUEUE_EN
            // Chain straight into the queued (or just-arrived) request
            if (pending_q) begin
              load_c      = 1'b1;
              load_data_c = pending_data_q;
              pending_d   = 1'b0;
            end else if (accept_c) begin
              load_c    = 1'b1;
              pending_d = 1'b0;
            end
`endif
          end else if (bit_cnt_inc_c == CNT_SYNC) begin
            state_d = ST_SYNC;
          end else if (bit_cnt_inc_c == CNT_DATA) begin
            state_d = ST_DATA;
          end
        end
      end
    endcase

    // Frame load overrides the end-of-frame idle values
    if (load_c) begin
      shreg_d   = {PREAMBLE, SYNCWORD, load_data_c};
      dataout_d = PREAMBLE[PREAMBLE_WIDTH-1];
      bit_cnt_d = '0;
      state_d   = ST_PREAMBLE;
      busy_d    = 1'b1;
    end

`ifdef ASK_TX_QUEUE_EN
    ready_d = ~pending_d;
`else
    ready_d = ~busy_d;
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      dataout_q <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      dataout_q <= dataout_d;
      sent_q    <= sent_d;
    end
  end

`ifdef ASK_TX_QUEUE_EN
  // One-entry pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= 1'b0;
      pending_data_q <= '0;
    end else begin
      pending_q      <= pending_d;
      pending_data_q <= pending_data_d;
    end
  end
`endif

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign dataout = dataout_q;
  assign sent    = sent_q;

endmodule

// File: tb/tb_ask_frame_tx.sv
// Self-checking bench for ask_frame_tx: default-prescaler instance plus a
// prescaler-1 instance, compared against a frame-level reference model.
module tb_ask_frame_tx;

  localparam int P     = 4;
  localparam int NSYM  = 24;
  localparam int FRAME = NSYM * P;

`ifdef ASK_TX_QUEUE_EN
  localparam logic RDY_BUSY = 1'b1;
`else
  localparam logic RDY_BUSY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       send, send1;
  logic [7:0] data, data1;
  logic       ready, busy, dataout, sent;
  logic       ready1, busy1, dataout1, sent1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ask_frame_tx dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .send    (send),
    .ready   (ready),
    .busy    (busy),
    .dataout (dataout),
    .sent    (sent)
  );

  ask_frame_tx #(.SYMBCLK_PRESCALER(1)) dut_p1 (
    .clk     (clk),
    .reset   (reset),
    .data    (data1),
    .send    (send1),
    .ready   (ready1),
    .busy    (busy1),
    .dataout (dataout1),
    .sent    (sent1)
  );

  // Reference: symbol idx of the on-air frame preamble|syncword|payload
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    logic [23:0] f;
    f = {8'b1010_1010, 8'b1110_0101, d};
    return f[23 - idx];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; send = 1'b0; send1 = 1'b0; data = '0; data1 = '0;
    tick; tick;
    checks++;
    if ({ready, busy, dataout, sent} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_held got rdy/busy/dout/sent=%b exp 1000", {ready, busy, dataout, sent});
    end
    checks++;
    if ({ready1, busy1, dataout1, sent1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_held_p1 got rdy/busy/dout/sent=%b exp 1000", {ready1, busy1, dataout1, sent1});
    end
    reset = 1'b0;
    tick;
    checks++;
    if ({ready, busy, dataout, sent} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release got rdy/busy/dout/sent=%b exp 1000", {ready, busy, dataout, sent});
    end
  endtask

  task automatic test_frame(input logic [7:0] d);
    logic [3:0] e;
    send = 1'b1; data = d;
    tick;
    send = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      e = {1'b1, RDY_BUSY, 1'b0, exp_bit(d, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL frame d=%h cycle %0d got busy/rdy/sent/dout=%b exp %b", d, k, {busy, ready, sent, dataout}, e);
      end
      data = 8'($urandom);
      tick;
    end
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0110) begin
      errors++;
      $display("FAIL frame_end d=%h got busy/rdy/sent/dout=%b exp 0110", d, {busy, ready, sent, dataout});
    end
    tick;
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0100) begin
      errors++;
      $display("FAIL frame_after d=%h got busy/rdy/sent/dout=%b exp 0100", d, {busy, ready, sent, dataout});
    end
  endtask

`ifdef ASK_TX_QUEUE_EN
  task automatic test_queue;
    logic [7:0] d;
    logic [3:0] e;
    d = 8'($urandom);
    send = 1'b1; data = d;
    tick;
    send = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      if (k == 10) begin send = 1'b1; data = 8'h5A; end
      else begin send = 1'b0; data = 8'($urandom); end
      e = {1'b1, (k <= 10), 1'b0, exp_bit(d, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL queue_f1 cycle %0d got busy/rdy/sent/dout=%b exp %b", k, {busy, ready, sent, dataout}, e);
      end
      tick;
    end
    send = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      e = {1'b1, 1'b1, (k == 1), exp_bit(8'h5A, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL queue_f2 cycle %0d got busy/rdy/sent/dout=%b exp %b", k, {busy, ready, sent, dataout}, e);
      end
      tick;
    end
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0110) begin
      errors++;
      $display("FAIL queue_end got busy/rdy/sent/dout=%b exp 0110", {busy, ready, sent, dataout});
    end
    tick;
  endtask
`else
  task automatic test_ignore_busy;
    logic [7:0] d;
    logic [3:0] e;
    d = 8'($urandom);
    send = 1'b1; data = d;
    tick;
    for (int k = 1; k <= FRAME; k++) begin
      if (k == 40) begin send = 1'b1; data = ~d; end
      else send = 1'b0;
      e = {1'b1, 1'b0, 1'b0, exp_bit(d, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d got busy/rdy/sent/dout=%b exp %b", k, {busy, ready, sent, dataout}, e);
      end
      tick;
    end
    send = 1'b0;
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0110) begin
      errors++;
      $display("FAIL ignore_busy_end got busy/rdy/sent/dout=%b exp 0110", {busy, ready, sent, dataout});
    end
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++;
      if ({busy, ready, sent, dataout} !== 4'b0100) begin
        errors++;
        $display("FAIL ignore_busy_idle +%0d got busy/rdy/sent/dout=%b exp 0100", k, {busy, ready, sent, dataout});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    send = 1'b1; data = 8'h3C;
    tick;
    data = 8'hC3;
    for (int k = 1; k <= FRAME; k++) begin
      e = {1'b1, 1'b0, 1'b0, exp_bit(8'h3C, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL b2b_f1 cycle %0d got busy/rdy/sent/dout=%b exp %b", k, {busy, ready, sent, dataout}, e);
      end
      tick;
    end
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_gap got busy/rdy/sent/dout=%b exp 0110", {busy, ready, sent, dataout});
    end
    tick;
    for (int k = 1; k <= FRAME; k++) begin
      send = 1'b0;
      e = {1'b1, 1'b0, 1'b0, exp_bit(8'hC3, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL b2b_f2 cycle %0d got busy/rdy/sent/dout=%b exp %b", k, {busy, ready, sent, dataout}, e);
      end
      tick;
    end
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_end got busy/rdy/sent/dout=%b exp 0110", {busy, ready, sent, dataout});
    end
    tick;
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] d;
    logic [3:0] e;
    d = 8'($urandom);
    send = 1'b1; data = d;
    tick;
    send = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      e = {1'b1, RDY_BUSY, 1'b0, exp_bit(d, (k - 1) / P)};
      checks++;
      if ({busy, ready, sent, dataout} !== e) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d got busy/rdy/sent/dout=%b exp %b", k, {busy, ready, sent, dataout}, e);
      end
      if (k == 50) reset = 1'b1;
      tick;
    end
    reset = 1'b0;
    checks++;
    if ({busy, ready, sent, dataout} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_abort got busy/rdy/sent/dout=%b exp 0100", {busy, ready, sent, dataout});
    end
    for (int k = 0; k < 60; k++) begin
      tick;
      checks++;
      if ({busy, ready, sent, dataout} !== 4'b0100) begin
        errors++;
        $display("FAIL reset_mid_idle +%0d got busy/rdy/sent/dout=%b exp 0100", k, {busy, ready, sent, dataout});
      end
    end
    test_frame(8'($urandom));
  endtask

  task automatic test_p1(input logic [7:0] d);
    logic [3:0] e;
    send1 = 1'b1; data1 = d;
    tick;
    send1 = 1'b0;
    for (int k = 1; k <= NSYM; k++) begin
      e = {1'b1, RDY_BUSY, 1'b0, exp_bit(d, k - 1)};
      checks++;
      if ({busy1, ready1, sent1, dataout1} !== e) begin
        errors++;
        $display("FAIL p1 d=%h cycle %0d got busy/rdy/sent/dout=%b exp %b", d, k, {busy1, ready1, sent1, dataout1}, e);
      end
      data1 = 8'($urandom);
      tick;
    end
    checks++;
    if ({busy1, ready1, sent1, dataout1} !== 4'b0110) begin
      errors++;
      $display("FAIL p1_end d=%h got busy/rdy/sent/dout=%b exp 0110", d, {busy1, ready1, sent1, dataout1});
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_frame(8'hA5);
    repeat (3) test_frame(8'($urandom));
`ifdef ASK_TX_QUEUE_EN
    test_queue;
`else
    test_ignore_busy;
    test_back_to_back;
`endif
    test_reset_mid;
    test_p1(8'hFF);
    test_p1(8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
